// File: rtl/skein_pkg.sv
// Shared Skein-1024 definitions: block width, key-selector mode encodings and
// the UBI chain controller state enumeration.
package skein_pkg;

  localparam int unsigned BLK_W  = 1024;
  localparam int unsigned DIST_W = 11;

  localparam logic MODE_MSG = 1'b0;
  localparam logic MODE_OUT = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StMsgWait,
    StOutWait
  } ubi_state_e;

endpackage

// File: rtl/popcount_1024.sv
// Combinational population count of a 1024-bit word; no pipeline registers.
module popcount_1024
  import skein_pkg::*;
(
  input  logic [BLK_W-1:0]  data_i,
  output logic [DIST_W-1:0] count_o
);

  // Per-byte counts first, then a flat sum; synthesis balances the final adders.
  logic [3:0] w_byte_cnt [BLK_W/8];

  always_comb begin
    for (int b = 0; b < BLK_W / 8; b++) begin
      w_byte_cnt[b] = '0;
      for (int i = 0; i < 8; i++) begin
        w_byte_cnt[b] = w_byte_cnt[b] + 4'(data_i[b*8+i]);
      end
    end
  end

  always_comb begin
    count_o = '0;
    for (int b = 0; b < BLK_W / 8; b++) begin
      count_o = count_o + DIST_W'(w_byte_cnt[b]);
    end
  end

endmodule

// File: rtl/ubi_chain_ctrl.sv
// Skein-1024 UBI chain return path: feed-forward, two-pass sequencing, watchdog.
// Optional Hamming-distance output is enabled by defining UBI_DIST_EN.
module ubi_chain_ctrl #(
  parameter int unsigned BLK_W   = skein_pkg::BLK_W,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         start_i,
  input  logic [BLK_W-1:0]             msg_i,
  input  logic                         cipher_valid_i,
  input  logic [BLK_W-1:0]             cipher_i,
`ifdef UBI_DIST_EN
  input  logic [BLK_W-1:0]             target_i,
  output logic [skein_pkg::DIST_W-1:0] dist_o,
  output logic                         dist_valid_o,
`endif
  output logic                         tf_start_o,
  output logic                         mode_o,
  output logic [BLK_W-1:0]             chain_o,
  output logic [BLK_W-1:0]             plain_o,
  output logic                         hash_valid_o,
  output logic [BLK_W-1:0]             hash_o,
  output logic                         busy_o,
  output logic                         timeout_o
);

  import skein_pkg::*;

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

  ubi_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_mode, w_mode_nxt;
  logic [BLK_W-1:0] r_chain, w_chain_nxt;
  logic [BLK_W-1:0] r_plain, w_plain_nxt;
  logic [BLK_W-1:0] r_hash, w_hash_nxt;
  logic             r_tf_start, w_tf_start_nxt;
  logic             r_hash_valid, w_hash_valid_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             w_expired;

  assign w_expired = (r_cnt == TimeoutLast);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_mode_nxt       = r_mode;
    w_chain_nxt      = r_chain;
    w_plain_nxt      = r_plain;
    w_hash_nxt       = r_hash;
    w_tf_start_nxt   = 1'b0;
    w_hash_valid_nxt = 1'b0;
    w_timeout_nxt    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start_i) begin
          w_plain_nxt    = msg_i;
          w_mode_nxt     = MODE_MSG;
          w_tf_start_nxt = 1'b1;
          w_cnt_nxt      = '0;
          w_state_nxt    = StMsgWait;
        end
      end
      StMsgWait: begin
        if (cipher_valid_i) begin
          // Output pass encrypts the all-zero counter block under the chained key.
          w_chain_nxt    = cipher_i ^ r_plain;
          w_plain_nxt    = '0;
          w_mode_nxt     = MODE_OUT;
          w_tf_start_nxt = 1'b1;
          w_cnt_nxt      = '0;
          w_state_nxt    = StOutWait;
        end else if (w_expired) begin
          w_timeout_nxt = 1'b1;
          w_mode_nxt    = MODE_MSG;
          w_cnt_nxt     = '0;
          w_state_nxt   = StIdle;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      StOutWait: begin
        if (cipher_valid_i) begin
          w_hash_nxt       = cipher_i ^ r_plain;
          w_hash_valid_nxt = 1'b1;
          w_mode_nxt       = MODE_MSG;
          w_cnt_nxt        = '0;
          w_state_nxt      = StIdle;
        end else if (w_expired) begin
          w_timeout_nxt = 1'b1;
          w_mode_nxt    = MODE_MSG;
          w_cnt_nxt     = '0;
          w_state_nxt   = StIdle;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_mode       <= MODE_MSG;
      r_chain      <= '0;
      r_plain      <= '0;
      r_hash       <= '0;
      r_tf_start   <= 1'b0;
      r_hash_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_mode       <= w_mode_nxt;
      r_chain      <= w_chain_nxt;
      r_plain      <= w_plain_nxt;
      r_hash       <= w_hash_nxt;
      r_tf_start   <= w_tf_start_nxt;
      r_hash_valid <= w_hash_valid_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  assign tf_start_o   = r_tf_start;
  assign mode_o       = r_mode;
  assign chain_o      = r_chain;
  assign plain_o      = r_plain;
  assign hash_valid_o = r_hash_valid;
  assign hash_o       = r_hash;
  assign timeout_o    = r_timeout;
  assign busy_o       = (r_state != StIdle);

`ifdef UBI_DIST_EN
  logic [DIST_W-1:0] w_dist;
  logic [DIST_W-1:0] r_dist;
  logic              r_dist_valid;

  popcount_1024 u_popcount (
    .data_i  (r_hash ^ target_i),
    .count_o (w_dist)
  );

  // Distance is taken on the hash registered in the hash_valid_o cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_dist       <= '0;
      r_dist_valid <= 1'b0;
    end else begin
      r_dist_valid <= r_hash_valid;
      if (r_hash_valid) begin
        r_dist <= w_dist;
      end
    end
  end

  assign dist_o       = r_dist;
  assign dist_valid_o = r_dist_valid;
`endif

endmodule

// File: tb/tb_ubi_chain_ctrl.sv
// Directed self-checking bench for ubi_chain_ctrl (TIMEOUT=5); the distance
// checks run only when UBI_DIST_EN is defined.
module tb_ubi_chain_ctrl;

  localparam int unsigned W = 1024;

  localparam logic [W-1:0] ONES   = {W{1'b1}};
  localparam logic [W-1:0] C_0F   = 1024'h0F;
  localparam logic [W-1:0] C_A5   = {128{8'hA5}};
  localparam logic [W-1:0] C_FF   = {16{64'hC0FFEE00DEADBEEF}};
  localparam logic [W-1:0] M_LOW  = {960'b0, 64'h1DE0536E8682E539};
  localparam logic [W-1:0] M_OV   = {16{64'h0123456789ABCDEF}};
  localparam logic [W-1:0] C_OV1  = {16{64'hFFFF0000FFFF0000}};
  localparam logic [W-1:0] X_OV1  = {16{64'hFEDC45677654CDEF}};
  localparam logic [W-1:0] C_OV2  = {16{64'h5555AAAA3333CCCC}};
  localparam logic [W-1:0] C_OV3  = {16{64'h0000000000000001}};
  localparam logic [W-1:0] X_OV3  = {16{64'h0123456789ABCDEE}};
  localparam logic [W-1:0] C_OV4  = {16{64'h8000000000000000}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] msg = '0;
  logic         cv = 1'b0;
  logic [W-1:0] cipher = '0;
  logic         tf_start_o, mode_o, hash_valid_o, busy_o, timeout_o;
  logic [W-1:0] chain_o, plain_o, hash_o;
`ifdef UBI_DIST_EN
  logic [W-1:0] target = '0;
  logic [10:0]  dist_o;
  logic         dist_valid_o;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ubi_chain_ctrl #(
    .BLK_W   (W),
    .TIMEOUT (5),
    .CNT_W   (8)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .msg_i          (msg),
    .cipher_valid_i (cv),
    .cipher_i       (cipher),
`ifdef UBI_DIST_EN
    .target_i       (target),
    .dist_o         (dist_o),
    .dist_valid_o   (dist_valid_o),
`endif
    .tf_start_o     (tf_start_o),
    .mode_o         (mode_o),
    .chain_o        (chain_o),
    .plain_o        (plain_o),
    .hash_valid_o   (hash_valid_o),
    .hash_o         (hash_o),
    .busy_o         (busy_o),
    .timeout_o      (timeout_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [W-1:0] m);
    start = 1'b1;
    msg   = m;
    tick();
    start = 1'b0;
  endtask

  // Ciphertext is sampled on the (n+1)th edge after the call.
  task automatic drive_cipher(input logic [W-1:0] ct, input int n);
    repeat (n) tick();
    cv     = 1'b1;
    cipher = ct;
    tick();
    cv     = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({tf_start_o, mode_o, hash_valid_o, busy_o, timeout_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {tf_start_o, mode_o, hash_valid_o, busy_o, timeout_o});
    end
    n_cmp++;
    if ((chain_o | plain_o | hash_o) !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got chain|plain|hash[63:0]=%h want 0",
               chain_o[63:0] | plain_o[63:0] | hash_o[63:0]);
    end
`ifdef UBI_DIST_EN
    n_cmp++;
    if ({dist_valid_o, dist_o} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_dist: got %0d/%0d want 0/0", dist_valid_o, dist_o);
    end
`endif
    rst_n = 1'b1;
    tick();
    cv     = 1'b1;
    cipher = ONES;
    tick();
    cv     = 1'b0;
    tick();
    n_cmp++;
    if ({busy_o, hash_valid_o, tf_start_o, mode_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_stray_ctrl: got %b want 0000",
               {busy_o, hash_valid_o, tf_start_o, mode_o});
    end
    n_cmp++;
    if ((chain_o | hash_o) !== '0) begin
      n_fail++;
      $display("FAIL idle_stray_data: got %h want 0", chain_o[63:0] | hash_o[63:0]);
    end
  endtask

  task automatic test_nominal;
    drive_start('0);
    n_cmp++;
    if ({tf_start_o, mode_o, busy_o} !== 3'b101) begin
      n_fail++;
      $display("FAIL nom_launch: got %b want 101", {tf_start_o, mode_o, busy_o});
    end
    drive_cipher(C_0F, 3);
    n_cmp++;
    if (chain_o !== C_0F) begin
      n_fail++;
      $display("FAIL nom_chain: got %h want %h", chain_o[127:0], C_0F[127:0]);
    end
    n_cmp++;
    if ({mode_o, tf_start_o, busy_o} !== 3'b111 || plain_o !== '0) begin
      n_fail++;
      $display("FAIL nom_out_launch: got %b plain=%h want 111 plain=0",
               {mode_o, tf_start_o, busy_o}, plain_o[63:0]);
    end
    repeat (3) tick();
    n_cmp++;
    if (hash_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_early_valid: got %b want 0", hash_valid_o);
    end
    cv     = 1'b1;
    cipher = C_A5;
    tick();
    cv     = 1'b0;
    n_cmp++;
    if (hash_valid_o !== 1'b1 || hash_o !== C_A5) begin
      n_fail++;
      $display("FAIL nom_hash: got v=%b %h want v=1 %h", hash_valid_o, hash_o[127:0],
               C_A5[127:0]);
    end
    n_cmp++;
    if ({mode_o, busy_o} !== 2'b00 || chain_o !== C_0F) begin
      n_fail++;
      $display("FAIL nom_done: got mode/busy=%b chain=%h want 00 chain=%h",
               {mode_o, busy_o}, chain_o[63:0], C_0F[63:0]);
    end
    tick();
    n_cmp++;
    if (hash_valid_o !== 1'b0 || hash_o !== C_A5) begin
      n_fail++;
      $display("FAIL nom_hold: got v=%b %h want v=0 %h", hash_valid_o, hash_o[63:0],
               C_A5[63:0]);
    end
  endtask

  task automatic test_feed_forward;
    drive_start(ONES);
    drive_cipher(ONES, 1);
    n_cmp++;
    if (chain_o !== '0) begin
      n_fail++;
      $display("FAIL ff_ones: got %h want 0", chain_o[127:0]);
    end
    drive_cipher(C_A5, 1);
    tick();
    drive_start(M_LOW);
    drive_cipher('0, 2);
    n_cmp++;
    if (chain_o !== M_LOW) begin
      n_fail++;
      $display("FAIL ff_low_word: got %h want %h", chain_o[127:0], M_LOW[127:0]);
    end
    drive_cipher(C_FF, 2);
    n_cmp++;
    if (hash_valid_o !== 1'b1 || hash_o !== C_FF) begin
      n_fail++;
      $display("FAIL ff_hash: got v=%b %h want v=1 %h", hash_valid_o, hash_o[127:0],
               C_FF[127:0]);
    end
    tick();
  endtask

  task automatic test_timeout;
    drive_start(ONES);
    repeat (4) tick();
    n_cmp++;
    if ({timeout_o, busy_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL to_msg_early: got %b want 01", {timeout_o, busy_o});
    end
    tick();
    n_cmp++;
    if ({timeout_o, busy_o, hash_valid_o, mode_o} !== 4'b1000) begin
      n_fail++;
      $display("FAIL to_msg_pulse: got %b want 1000",
               {timeout_o, busy_o, hash_valid_o, mode_o});
    end
    n_cmp++;
    if (hash_o !== C_FF) begin
      n_fail++;
      $display("FAIL to_msg_hash: got %h want %h", hash_o[63:0], C_FF[63:0]);
    end
    tick();
    n_cmp++;
    if (timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL to_one_cycle: got %b want 0", timeout_o);
    end
    drive_cipher(ONES, 0);
    tick();
    n_cmp++;
    if ({busy_o, hash_valid_o, tf_start_o} !== 3'b000 || hash_o !== C_FF) begin
      n_fail++;
      $display("FAIL to_stray: got %b %h want 000 %h", {busy_o, hash_valid_o, tf_start_o},
               hash_o[63:0], C_FF[63:0]);
    end
    drive_start('0);
    drive_cipher(C_A5, 1);
    repeat (4) tick();
    n_cmp++;
    if ({timeout_o, mode_o, busy_o} !== 3'b011) begin
      n_fail++;
      $display("FAIL to_out_early: got %b want 011", {timeout_o, mode_o, busy_o});
    end
    tick();
    n_cmp++;
    if ({timeout_o, mode_o, busy_o, hash_valid_o} !== 4'b1000 || hash_o !== C_FF) begin
      n_fail++;
      $display("FAIL to_out_pulse: got %b %h want 1000 %h",
               {timeout_o, mode_o, busy_o, hash_valid_o}, hash_o[63:0], C_FF[63:0]);
    end
    tick();
  endtask

  task automatic test_overlap;
    int n_tf;
    n_tf  = 0;
    start = 1'b1;
    msg   = M_OV;
    tick();
    n_cmp++;
    if (tf_start_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ov_launch: got %b want 1", tf_start_o);
    end
    for (int c = 1; c <= 6; c++) begin
      cv     = (c == 3 || c == 6);
      cipher = (c == 3) ? C_OV1 : C_OV2;
      tick();
      if (tf_start_o === 1'b1) n_tf++;
    end
    cv = 1'b0;
    n_cmp++;
    if (n_tf !== 1) begin
      n_fail++;
      $display("FAIL ov_tf_count: got %0d want 1", n_tf);
    end
    n_cmp++;
    if (hash_valid_o !== 1'b1 || hash_o !== C_OV2 || chain_o !== X_OV1) begin
      n_fail++;
      $display("FAIL ov_hash: got v=%b %h chain=%h want v=1 %h chain=%h", hash_valid_o,
               hash_o[63:0], chain_o[63:0], C_OV2[63:0], X_OV1[63:0]);
    end
    tick();
    start = 1'b0;
    n_cmp++;
    if ({tf_start_o, busy_o, hash_valid_o} !== 3'b110) begin
      n_fail++;
      $display("FAIL ov_reaccept: got %b want 110", {tf_start_o, busy_o, hash_valid_o});
    end
    drive_cipher(C_OV3, 4);
    n_cmp++;
    if (chain_o !== X_OV3 || {timeout_o, mode_o, tf_start_o} !== 3'b011) begin
      n_fail++;
      $display("FAIL ov_race_msg: got %h %b want %h 011", chain_o[63:0],
               {timeout_o, mode_o, tf_start_o}, X_OV3[63:0]);
    end
    drive_cipher(C_OV4, 4);
    n_cmp++;
    if ({hash_valid_o, timeout_o} !== 2'b10 || hash_o !== C_OV4) begin
      n_fail++;
      $display("FAIL ov_race_out: got %b %h want 10 %h", {hash_valid_o, timeout_o},
               hash_o[63:0], C_OV4[63:0]);
    end
    tick();
    n_cmp++;
    if ({timeout_o, busy_o, hash_valid_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL ov_race_after: got %b want 000", {timeout_o, busy_o, hash_valid_o});
    end
  endtask

  task automatic test_async_reset;
    drive_start(ONES);
    drive_cipher(C_A5, 1);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy_o, mode_o, tf_start_o} !== 3'b000 || (chain_o | plain_o | hash_o) !== '0) begin
      n_fail++;
      $display("FAIL areset: got %b data=%h want 000 data=0", {busy_o, mode_o, tf_start_o},
               chain_o[63:0] | plain_o[63:0] | hash_o[63:0]);
    end
    tick();
    rst_n = 1'b1;
    tick();
    drive_cipher(C_A5, 0);
    tick();
    n_cmp++;
    if ({busy_o, hash_valid_o, tf_start_o} !== 3'b000 || hash_o !== '0) begin
      n_fail++;
      $display("FAIL areset_stray: got %b %h want 000 0", {busy_o, hash_valid_o, tf_start_o},
               hash_o[63:0]);
    end
  endtask

`ifdef UBI_DIST_EN
  task automatic test_dist;
    target = '0;
    drive_start('0);
    drive_cipher(C_0F, 1);
    drive_cipher(ONES, 1);
    n_cmp++;
    if ({hash_valid_o, dist_valid_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL dist_early: got %b want 10", {hash_valid_o, dist_valid_o});
    end
    tick();
    n_cmp++;
    if (dist_valid_o !== 1'b1 || dist_o !== 11'd1024) begin
      n_fail++;
      $display("FAIL dist_ones: got v=%b %0d want v=1 1024", dist_valid_o, dist_o);
    end
    tick();
    n_cmp++;
    if (dist_valid_o !== 1'b0 || dist_o !== 11'd1024) begin
      n_fail++;
      $display("FAIL dist_hold: got v=%b %0d want v=0 1024", dist_valid_o, dist_o);
    end
    target = ONES;
    drive_start('0);
    drive_cipher(C_0F, 1);
    drive_cipher(ONES, 1);
    tick();
    n_cmp++;
    if (dist_valid_o !== 1'b1 || dist_o !== 11'd0) begin
      n_fail++;
      $display("FAIL dist_equal: got v=%b %0d want v=1 0", dist_valid_o, dist_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_feed_forward();
    test_timeout();
    test_overlap();
`ifdef UBI_DIST_EN
    test_dist();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ubi_chain_ctrl.md
Name: ubi_chain_ctrl

Overview:
- Return path of the Skein-1024 UBI chain around the Threefish-1024 core.
- Captures each ciphertext block and applies the UBI feed-forward (ciphertext XOR plaintext).
- Sequences the two UBI passes (message block, then output block) and drives the key selector: mode_o feeds its mode input, chain_o feeds its key input.
- Presents the final 1024-bit hash with a one-cycle valid strobe.

Parameters:
- BLK_W, 1024, state/key/block width in bits; only 1024 is supported.
- TIMEOUT, 255, maximum cycles to wait for cipher_valid_i before aborting; must be ≥1.
- CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  request to hash one message block; accepted only in IDLE.
- msg_i  in  BLK_W  message block, sampled on the accepted start_i cycle.
- cipher_valid_i  in  1  Threefish result strobe, one cycle.
- cipher_i  in  BLK_W  Threefish ciphertext, valid with cipher_valid_i.
- tf_start_o  out  1  one-cycle pulse that launches a Threefish pass.
- mode_o  out  1  key-select mode: 0 = message pass (IV key), 1 = output pass (chained key).
- chain_o  out  BLK_W  registered chaining value to the key selector.
- plain_o  out  BLK_W  registered Threefish plaintext.
- hash_valid_o  out  1  one-cycle strobe; hash_o is valid in that cycle.
- hash_o  out  BLK_W  final hash, held until the next hash completes.
- busy_o  out  1  high in every state except IDLE.
- timeout_o  out  1  one-cycle pulse when the watchdog aborts a pass.

Behaviour:
- Reset: state=IDLE; all outputs 0, including chain_o, plain_o and hash_o; watchdog counter 0.
- States: IDLE, MSG_WAIT, OUT_WAIT.
- IDLE + start_i:
  - plain_o<=msg_i; mode_o<=0; tf_start_o=1 next cycle; counter<=0; go to MSG_WAIT.
  - tf_start_o is asserted in the same cycle mode_o/plain_o become valid.
- MSG_WAIT + cipher_valid_i:
  - chain_o<=cipher_i^plain_o; plain_o<=0 (output-pass input is the zero counter block); mode_o<=1.
  - Pulse tf_start_o next cycle; counter<=0; go to OUT_WAIT.
- OUT_WAIT + cipher_valid_i:
  - hash_o<=cipher_i^plain_o (equals cipher_i); hash_valid_o=1 for one cycle; mode_o<=0; go to IDLE.
  - chain_o retains the message-pass chaining value.
- Watchdog, in MSG_WAIT/OUT_WAIT without cipher_valid_i:
  - counter increments each cycle.
  - When counter==TIMEOUT-1: timeout_o pulses, mode_o<=0, state goes to IDLE, hash_o is unchanged, hash_valid_o stays low.
  - cipher_valid_i arriving in the same cycle wins; no timeout in that case.
- cipher_valid_i in IDLE is ignored.
- start_i outside IDLE is ignored; no queueing.
- Back-to-back: start_i may be accepted in the cycle immediately after hash_valid_o.
- Latency, start_i to hash_valid_o: 2 + 2×L cycles, where L = Threefish latency from tf_start_o to cipher_valid_i.
- Asynchronous reset mid-pass aborts immediately. A later stray cipher_valid_i is ignored.
- The XOR is bitwise over BLK_W bits; there is no carry or arithmetic.

Optional Feature:
- Macro: UBI_DIST_EN.
- When defined:
  - Adds input target_i[BLK_W-1:0] and outputs dist_o[10:0] and dist_valid_o.
  - dist_o = popcount(hash_o ^ target_i), registered.
  - dist_valid_o pulses exactly one cycle after hash_valid_o.
  - dist_o holds until the next update; reset value 0.
- When undefined: those ports and the logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (skein_pkg):
  - BLK_W=1024.
  - Mode encodings MODE_MSG=1'b0 and MODE_OUT=1'b1, shared with the key selector.
  - State enumeration for ubi_chain_ctrl.
  - DIST_W=11.
- Sub-module: popcount_1024, a pipelined-free adder tree, instantiated only under UBI_DIST_EN.

Test Plan:
- Reset: hold rst_n_i=0, then release -> every output 0, busy_o=0; cipher_valid_i pulses while IDLE cause no change.
- Nominal hash, model L=3:
  - Stimulus: msg_i=all zeros; first cipher_i=1024'h...0F; second cipher_i=1024'hA5 repeated.
  - Required: chain_o=...0F; mode_o goes 0->1; hash_o=A5 pattern; hash_valid_o high for one cycle, 8 cycles after start_i.
- Feed-forward: msg_i=all ones, cipher_i=all ones -> chain_o=0; msg_i=64'h1DE0...539 in low word, cipher_i=0 -> chain_o low word=64'h1DE0536E8682E539.
- Timeout: TIMEOUT=5, never assert cipher_valid_i -> timeout_o pulses 5 cycles after tf_start_o; state IDLE; hash_o retains its previous value.
- Overlap: start_i held high through a full hash, plus cipher_valid_i and timeout coinciding -> exactly one hash per IDLE entry; valid wins over timeout.
- UBI_DIST_EN: target_i=0, hash_o=all ones -> dist_o=1024 with dist_valid_o one cycle after hash_valid_o; hash_o==target_i -> dist_o=0.
